// File: rtl/video_pattern_gen.sv
// video_pattern_gen: configurable video timing generator with optional test patterns.
// Define VPG_PATTERN_EN to compile in the pattern source; otherwise r/g/b are constant 0.
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 80,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 16,
  parameter int HW       = 12,
  parameter int VW       = 12
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [1:0]    ce_div,
  input  logic          dbl,
  input  logic [1:0]    pattern,
  output logic          ce_pix,
  output logic [HW-1:0] hc,
  output logic [VW-1:0] vc,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [1:0]    r_div, r_ce_div_l;
  logic          r_dbl_l, r_ce_pix, r_hblank, r_vblank, r_hsync, r_vsync, r_de;
  logic          r_line_start, r_frame_start;
  logic [HW-1:0] r_hc, w_hc_n;
  logic [VW-1:0] r_vc, w_vc_n, w_vl, w_vmax;
  logic [7:0]    r_frame_cnt, w_fc_n;
  logic          w_ce, w_hwrap, w_vlast, w_fs, w_hb, w_vb, w_hs, w_vs, w_de;
  // Decode is done on the next counter values so every registered output describes the same pixel.
  always_comb begin
    w_ce    = r_div == r_ce_div_l;
    w_hwrap = r_hc == HW'(H_TOTAL - 1);
    w_vmax  = r_dbl_l ? VW'(2 * V_TOTAL - 1) : VW'(V_TOTAL - 1);
    w_vlast = r_vc == w_vmax;
    w_fs    = w_hwrap && w_vlast;
    w_hc_n  = w_hwrap ? '0 : r_hc + HW'(1);
    w_vc_n  = !w_hwrap ? r_vc : w_vlast ? '0 : r_vc + VW'(1);
    w_vl    = r_dbl_l ? w_vc_n >> 1 : w_vc_n;
    w_hb    = w_hc_n >= HW'(H_ACTIVE);
    w_vb    = w_vl >= VW'(V_ACTIVE);
    w_hs    = w_hc_n >= HW'(H_ACTIVE + H_FP) && w_hc_n < HW'(H_ACTIVE + H_FP + H_SYNC);
    w_vs    = w_vl >= VW'(V_ACTIVE + V_FP) && w_vl < VW'(V_ACTIVE + V_FP + V_SYNC);
    w_de    = !w_hb && !w_vb;
    w_fc_n  = r_frame_cnt + 8'(w_fs);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_div         <= 2'd0;
      r_ce_div_l    <= 2'd0;
      r_dbl_l       <= 1'b0;
      r_ce_pix      <= 1'b0;
      r_hc          <= HW'(H_TOTAL - 1);
      r_vc          <= VW'(V_TOTAL - 1);
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_div    <= w_ce ? 2'd0 : r_div + 2'd1;
      r_ce_pix <= w_ce;
      if (w_ce) begin
        r_hc          <= w_hc_n;
        r_vc          <= w_vc_n;
        r_hblank      <= w_hb;
        r_vblank      <= w_vb;
        r_hsync       <= w_hs;
        r_vsync       <= w_vs;
        r_de          <= w_de;
        r_line_start  <= w_hwrap;
        r_frame_start <= w_fs;
        r_frame_cnt   <= w_fc_n;
        if (w_fs) begin
          r_ce_div_l <= ce_div;
          r_dbl_l    <= dbl;
        end
      end
    end
  end
  assign ce_pix      = r_ce_pix;
  assign hc          = r_hc;
  assign vc          = r_vc;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
`ifdef VPG_PATTERN_EN
  logic [1:0]    r_pat_l, w_pat_n;
  logic [2:0]    r_bar, w_bar_n;
  logic [HW-1:0] r_bar_px, w_bar_px_n;
  logic          w_seg_end;
  logic [7:0]    r_r, r_g, r_b, w_r, w_g, w_b, w_grad, w_grid;
  // Bar index walks white..black; each colour bit is the inverse of one index bit.
  always_comb begin
    w_pat_n    = w_fs ? pattern : r_pat_l;
    w_seg_end  = r_bar_px == HW'(H_ACTIVE / 8 - 1);
    w_bar_n    = w_hc_n == '0 ? 3'd0 : w_seg_end ? r_bar + 3'd1 : r_bar;
    w_bar_px_n = (w_hc_n == '0 || w_seg_end) ? '0 : r_bar_px + HW'(1);
    w_grad     = w_hc_n[7:0] + w_fc_n;
    w_grid     = (w_hc_n[3:0] == 4'd0 || w_vl[3:0] == 4'd0) ? 8'hFF : 8'h20;
    w_r = !w_de ? 8'h00 : w_pat_n == 2'd1 ? {8{~w_bar_n[1]}} : w_pat_n == 2'd2 ? w_grid : w_pat_n == 2'd3 ? w_grad : 8'h00;
    w_g = !w_de ? 8'h00 : w_pat_n == 2'd1 ? {8{~w_bar_n[2]}} : w_pat_n == 2'd2 ? w_grid : w_pat_n == 2'd3 ? w_grad : 8'h00;
    w_b = !w_de ? 8'h00 : w_pat_n == 2'd1 ? {8{~w_bar_n[0]}} : w_pat_n == 2'd2 ? w_grid : w_pat_n == 2'd3 ? w_grad : 8'h00;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pat_l  <= 2'd0;
      r_bar    <= 3'd0;
      r_bar_px <= '0;
      r_r      <= 8'h00;
      r_g      <= 8'h00;
      r_b      <= 8'h00;
    end else if (w_ce) begin
      r_pat_l  <= w_pat_n;
      r_bar    <= w_bar_n;
      r_bar_px <= w_bar_px_n;
      r_r      <= w_r;
      r_g      <= w_g;
      r_b      <= w_b;
    end
  end
  assign r = r_r;
  assign g = r_g;
  assign b = r_b;
`else
  logic w_unused;
  assign w_unused = ^pattern;
  assign r = 8'h00;
  assign g = 8'h00;
  assign b = 8'h00;
`endif
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: bench for video_pattern_gen on a reduced geometry.
// A pixel-index model checks every cycle; directed vectors pin frame statistics and patterns.
module tb_video_pattern_gen;
  localparam int HA = 32, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
`ifdef VPG_PATTERN_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, dbl = 1'b0;
  logic [1:0] ce_div = 2'd0, pattern = 2'd0;
  logic ce_pix, hblank, vblank, hsync, vsync, de, line_start, frame_start;
  logic [11:0] hc, vc;
  logic [7:0] frame_cnt, r, g, b;
  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .HW(12), .VW(12)
  ) dut (
    .clk_sys(clk), .reset(reset), .ce_div(ce_div), .dbl(dbl), .pattern(pattern),
    .ce_pix(ce_pix), .hc(hc), .vc(vc), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .de(de), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .r(r), .g(g), .b(b)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] pix(input int h, input int vl, input int pat, input int fc, input bit on);
    logic [7:0] y;
    y = 8'((h + fc) % 256);
    if (!on || !PEN) return 24'h0;
    case (pat)
      1: case (h / (HA / 8))
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return (h % 16 == 0 || vl % 16 == 0) ? 24'hFFFFFF : 24'h202020;
      3: return {y, y, y};
      default: return 24'h0;
    endcase
  endfunction
  logic s_reset = 1'b1, s_dbl = 1'b0;
  logic [1:0] s_div = 2'd0, s_pat = 2'd0;
  always @(posedge clk) begin
    s_reset <= reset;
    s_dbl   <= dbl;
    s_div   <= ce_div;
    s_pat   <= pattern;
  end
  int m_p, m_gap, m_dbl, m_div, m_pat, m_fc, h_e, v_e, vl_e;
  logic e_ce;
  logic [6:0] e_fl;
  int fs_seen = 0, clk_a = 0, ce_a = 0, ls_a = 0, de_a = 0, hs_a = 0;
  int hs_min = 9999, hs_max = -1, vs_min = 9999, vs_max = -1;
  int l_clk, l_ce, l_ls, l_de, l_hs, l_hs_min, l_hs_max, l_vs_min, l_vs_max;
  // Model: the frame is a flat run of pixel indices; position and decode follow by division.
  always @(negedge clk) begin
    if (s_reset) begin
      m_p = HT * VT - 1; m_gap = 0; m_dbl = 0; m_div = 0; m_pat = 0; m_fc = 0; e_ce = 1'b0;
    end else begin
      m_gap++;
      e_ce = (m_gap == m_div + 1);
      if (e_ce) begin
        m_gap = 0;
        m_p++;
        if (m_p == HT * (VT << m_dbl)) begin
          m_p = 0; m_dbl = int'(s_dbl); m_div = int'(s_div); m_pat = int'(s_pat); m_fc = (m_fc + 1) % 256;
        end
      end
    end
    h_e = m_p % HT; v_e = m_p / HT; vl_e = v_e >> m_dbl;
    e_fl = {h_e >= HA, vl_e >= VA, h_e >= HA + HFP && h_e < HA + HFP + HS,
            vl_e >= VA + VFP && vl_e < VA + VFP + VS, h_e < HA && vl_e < VA, h_e == 0, m_p == 0};
    chk("ce_pix", ce_pix, e_ce);
    chk("hc", hc, h_e);
    chk("vc", vc, v_e);
    chk("flags", {hblank, vblank, hsync, vsync, de, line_start, frame_start}, e_fl);
    chk("frame_cnt", frame_cnt, m_fc);
    chk("rgb", {r, g, b}, pix(h_e, vl_e, m_pat, m_fc, e_fl[2]));
    if (!s_reset) begin
      clk_a++;
      if (ce_pix) begin
        if (frame_start) begin
          l_clk = clk_a; l_ce = ce_a; l_ls = ls_a; l_de = de_a; l_hs = hs_a;
          l_hs_min = hs_min; l_hs_max = hs_max; l_vs_min = vs_min; l_vs_max = vs_max;
          clk_a = 0; ce_a = 0; ls_a = 0; de_a = 0; hs_a = 0;
          hs_min = 9999; hs_max = -1; vs_min = 9999; vs_max = -1;
          fs_seen++;
        end
        ce_a++;
        ls_a += int'(line_start);
        de_a += int'(de);
        if (hsync) begin hs_a++; hs_min = hs_min < int'(hc) ? hs_min : int'(hc); hs_max = hs_max > int'(hc) ? hs_max : int'(hc); end
        if (vsync) begin vs_min = vs_min < int'(vc) ? vs_min : int'(vc); vs_max = vs_max > int'(vc) ? vs_max : int'(vc); end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wait_fs(input int n);
    int tgt = fs_seen + n;
    int k = 0;
    while (fs_seen < tgt && k < 8000) begin step(1); k++; end
    chk("wait_frame_start", fs_seen, tgt);
  endtask
  task automatic wait_pos(input int vv, input int hh);
    int k = 0;
    while (!(int'(vc) == vv && int'(hc) == hh) && k < 4000) begin step(1); k++; end
    chk("wait_position", {vc[11:0], 4'd0, hc[11:0]}, {vv[11:0], 4'd0, hh[11:0]});
  endtask
  task automatic frame_stats(input int ls, input int dee, input int vs0, input int vs1, input int clks);
    chk("lines_per_frame", l_ls, ls);
    chk("de_count", l_de, dee);
    chk("ce_per_frame", l_ce, HT * ls);
    chk("hsync_start", l_hs_min, HA + HFP);
    chk("hsync_last", l_hs_max, HA + HFP + HS - 1);
    chk("hsync_total", l_hs, HS * ls);
    chk("vsync_first", l_vs_min, vs0);
    chk("vsync_last", l_vs_max, vs1);
    chk("clocks_per_frame", l_clk, clks);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    pattern = 2'd1;
    step(3);
    chk("reset_hc", hc, HT - 1);
    chk("reset_vc", vc, VT - 1);
    chk("reset_flags", {ce_pix, hblank, vblank, hsync, vsync, de, line_start, frame_start}, 8'b0110_0000);
    chk("reset_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    step(1);
    chk("first_ce_pos", {hc, vc}, 24'h0);
    chk("first_ce_flags", {ce_pix, frame_start, line_start, de}, 4'hF);
    chk("first_frame_cnt", frame_cnt, 1);
    chk("bar_hc0", {r, g, b}, PEN ? 24'hFFFFFF : 24'h0);
    wait_pos(0, 4);
    chk("bar_hc4", {r, g, b}, PEN ? 24'hFFFF00 : 24'h0);
    wait_pos(0, 31);
    chk("bar_hc31_de", de, 1);
    chk("bar_hc31", {r, g, b}, 24'h000000);
    wait_fs(1);
    frame_stats(VT, HA * VA, VA + VFP, VA + VFP + VS - 1, HT * VT);
    wait_pos(5, 0);
    dbl = 1'b1;
    ce_div = 2'd2;
    wait_fs(1);
    frame_stats(VT, HA * VA, VA + VFP, VA + VFP + VS - 1, HT * VT);
    wait_fs(1);
    frame_stats(2 * VT, HA * 2 * VA, 2 * (VA + VFP), 2 * (VA + VFP + VS) - 1, HT * 2 * VT * 3);
    pattern = 2'd3;
    dbl = 1'b0;
    ce_div = 2'd0;
    wait_fs(1);
    wait_pos(0, 10);
    chk("grad_frame_cnt", frame_cnt, 5);
    chk("grad_rgb", {r, g, b}, PEN ? 24'h0F0F0F : 24'h0);
    pattern = 2'd2;
    wait_fs(1);
    wait_pos(1, 16);
    chk("grid_line", {r, g, b}, PEN ? 24'hFFFFFF : 24'h0);
    step(1);
    chk("grid_fill", {r, g, b}, PEN ? 24'h202020 : 24'h0);
    reset = 1'b1;
    step(1);
    chk("midreset_pos", {hc, vc}, {12'(HT - 1), 12'(VT - 1)});
    chk("midreset_flags", {ce_pix, hblank, vblank, hsync, vsync, de, line_start, frame_start}, 8'b0110_0000);
    chk("midreset_frame_cnt", frame_cnt, 0);
    chk("midreset_rgb", {r, g, b}, 24'h0);
    reset = 1'b0;
    wait_fs(1);
    step(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
